shot_entry_ctrl: RTL and testbench
==================================

# shot_entry_ctrl

Turn and shot-entry controller for the two-player battleship game. It consumes the single-cycle pulses produced by the push-button debouncers: cursor X, cursor Y, fire and start. It maintains the aiming cursor and each player's shot history. It issues one shot request per turn to the board logic over a valid/ready handshake, then sequences the result display and the player swap.

## Interface
- GRID, 4, cells per board side (square board, GRID*GRID ≤ 64)
- CW, 2, coordinate width in bits; must satisfy 2^CW ≥ GRID
- HOLD_CYCLES, 50_000_000, cycles the result stays displayed before the turn passes (≥ 2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start_p  in  1  debounced start pulse
- movx_p  in  1  debounced pulse: cursor X +1
- movy_p  in  1  debounced pulse: cursor Y +1
- fire_p  in  1  debounced fire pulse
- shot_valid  out  1  shot request pending
- shot_ready  in  1  board logic accepts request
- shot_x  out  CW  shot column
- shot_y  out  CW  shot row
- shot_player  out  1  shooting player
- res_valid  in  1  single-cycle result strobe from board logic
- res_hit  in  1  result is a hit (qualified by res_valid)
- res_over  in  1  result sinks the last ship (qualified by res_valid)
- cur_x  out  CW  cursor column
- cur_y  out  CW  cursor row
- player  out  1  player to move
- hit_led  out  1  last result was a hit, high during SHOW only
- dup_err  out  1  one-cycle pulse: fire on an already-shot cell
- score0  out  3  hits by player 0, saturating at 7
- score1  out  3  hits by player 1, saturating at 7
- state_o  out  3  IDLE=0, AIM=1, REQ=2, WAIT=3, SHOW=4, DONE=5

## Operation
- Reset values: state IDLE; cur_x, cur_y, player, score0, score1, hit_led, dup_err and shot_valid all 0; both shot maps cleared.
- IDLE:
  - start_p → AIM.
  - All other inputs are ignored.
- AIM, movement:
  - movx_p sets cur_x ← (cur_x+1) mod GRID. movy_p does the same for cur_y.
  - Both pulses in the same cycle: both axes advance.
- AIM, fire:
  - Fire checks map[player][cur_y*GRID+cur_x].
  - Bit set: dup_err pulses for one cycle and the state stays AIM.
  - Bit clear: set the bit, latch shot_x/shot_y/shot_player from cursor/player, and go to REQ.
  - Fire takes priority over movement. Move pulses in the same cycle are dropped.
- REQ:
  - shot_valid = 1. shot_x/shot_y/shot_player stay stable.
  - When shot_valid & shot_ready is sampled, go to WAIT.
- WAIT:
  - Wait for res_valid.
  - On res_valid: hit_led ← res_hit. If res_hit, increment the current player's score (saturating at 7).
  - Then res_over → DONE, else → SHOW with the hold counter loaded.
- SHOW:
  - Count HOLD_CYCLES cycles, then: toggle player, set cur_x = cur_y = 0, clear hit_led, go to AIM.
- DONE:
  - player is frozen on the winner. hit_led = 1, scores are held.
  - start_p: clear both maps, scores and cursor; player ← 0; go to AIM.
- Pulses arriving outside their consuming state are discarded, never queued. This covers move/fire outside AIM and start outside IDLE/DONE.
- res_valid outside WAIT is ignored.
- start_p during AIM/REQ/WAIT/SHOW is ignored. Only rst aborts a game.

## Timing
- All outputs are registered.
- Pulse sampled at edge N: the effect is visible after edge N (cur_x, dup_err and shot_valid are all updated by edge N).
- fire_p → shot_valid: 1 cycle. The request can complete in the same cycle if shot_ready is already high.
- shot_valid drops the cycle after the handshake edge. It never drops before acceptance.
- res_valid at edge M: hit_led and score update at M, and state is SHOW or DONE at M.
- SHOW lasts exactly HOLD_CYCLES cycles. AIM is entered at edge M+HOLD_CYCLES.
- rst mid-REQ: shot_valid deasserts immediately (asynchronous). The board logic must drop a half-accepted request.
- Back-to-back move pulses on consecutive cycles each advance the cursor by one.

## Test plan
- Reset, start_p, three movx_p, two movy_p → cur_x=3, cur_y=2. One more movx_p → cur_x=0 (wrap).
- In AIM at (1,2), fire_p with shot_ready held low for 5 cycles:
  - shot_valid stays 1 with shot_x=1, shot_y=2, shot_player=0 throughout.
  - Raise shot_ready → state WAIT next cycle.
- Result sequencing, HOLD_CYCLES=4:
  - res_valid with res_hit=1 → score0=1, hit_led=1.
  - Exactly 4 cycles later: state AIM, player=1, cursor (0,0).
- Player 0 fires on (0,0) again on a later turn → dup_err pulse of one cycle, no shot_valid, state stays AIM.
- fire_p and movx_p in the same cycle at (2,0) → shot_x=2, cur_x stays 2.
- Game over and restart:
  - res_valid with res_hit=1, res_over=1 → DONE, player frozen.
  - Fire and move pulses are ignored.
  - start_p → AIM, scores 0, maps clear: a fire on a previously shot cell is accepted.

Source files
------------

// File: rtl/shot_entry_ctrl.sv
`timescale 1ns/1ps
// Purpose : battleship turn controller. It keeps the aiming cursor and per-player shot maps,
//           issues one shot request per turn, then sequences the result display and the player swap.
// Latency : every output is registered. A pulse sampled at edge N shows its effect after edge N.
//           fire_p -> shot_valid takes 1 cycle. SHOW lasts exactly HOLD_CYCLES cycles.
// Backpr. : shot_valid holds with stable shot_x/shot_y/shot_player until shot_ready is sampled.
//           Pulses that arrive outside their consuming state are dropped, not queued.
// Ports   : clk, rst (async, active-high); start_p/movx_p/movy_p/fire_p are debounced pulses;
//           shot_valid/shot_ready/shot_x/shot_y/shot_player form the request to the board logic;
//           res_valid/res_hit/res_over carry the result strobe; cur_x/cur_y/player/hit_led/dup_err/
//           score0/score1/state_o drive the display.
module shot_entry_ctrl #(
    parameter int GRID        = 4,
    parameter int CW          = 2,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_p,
    input  logic          movx_p,
    input  logic          movy_p,
    input  logic          fire_p,
    output logic          shot_valid,
    input  logic          shot_ready,
    output logic [CW-1:0] shot_x,
    output logic [CW-1:0] shot_y,
    output logic          shot_player,
    input  logic          res_valid,
    input  logic          res_hit,
    input  logic          res_over,
    output logic [CW-1:0] cur_x,
    output logic [CW-1:0] cur_y,
    output logic          player,
    output logic          hit_led,
    output logic          dup_err,
    output logic [2:0]    score0,
    output logic [2:0]    score1,
    output logic [2:0]    state_o
);

    localparam int CELLS = GRID * GRID;
    localparam int IW    = $clog2(CELLS);
    localparam int HW    = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AIM  = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_SHOW = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CELLS-1:0]  map0;
    logic [CELLS-1:0]  map1;
    logic [HW-1:0]     hold_cnt;
    logic [IW-1:0]     cell_idx;
    logic              cell_shot;
    logic [CW-1:0]     next_x;
    logic [CW-1:0]     next_y;

    // Row-major cell index of the cursor, used to look up the mover's own shot map.
    assign cell_idx  = IW'(int'(cur_y) * GRID + int'(cur_x));
    assign cell_shot = player ? map1[cell_idx] : map0[cell_idx];
    assign next_x    = (cur_x == CW'(GRID - 1)) ? '0 : cur_x + CW'(1);
    assign next_y    = (cur_y == CW'(GRID - 1)) ? '0 : cur_y + CW'(1);
    assign state_o   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start_p)               state_nx = S_AIM;
            S_AIM:  if (fire_p && !cell_shot)  state_nx = S_REQ;
            // shot_valid is always high in REQ, so ready alone completes the handshake.
            S_REQ:  if (shot_ready)            state_nx = S_WAIT;
            S_WAIT: if (res_valid)             state_nx = res_over ? S_DONE : S_SHOW;
            S_SHOW: if (hold_cnt == '0)        state_nx = S_AIM;
            S_DONE: if (start_p)               state_nx = S_AIM;
            default:                           state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x       <= '0;
            cur_y       <= '0;
            player      <= 1'b0;
            score0      <= 3'd0;
            score1      <= 3'd0;
            hit_led     <= 1'b0;
            dup_err     <= 1'b0;
            shot_valid  <= 1'b0;
            shot_x      <= '0;
            shot_y      <= '0;
            shot_player <= 1'b0;
            map0        <= '0;
            map1        <= '0;
            hold_cnt    <= '0;
        end else begin
            dup_err <= 1'b0;
            case (state)
                S_AIM: begin
                    // Fire wins over movement; a same-cycle move is dropped.
                    if (fire_p) begin
                        if (cell_shot) begin
                            dup_err <= 1'b1;
                        end else begin
                            if (player) map1[cell_idx] <= 1'b1;
                            else        map0[cell_idx] <= 1'b1;
                            shot_x      <= cur_x;
                            shot_y      <= cur_y;
                            shot_player <= player;
                            shot_valid  <= 1'b1;
                        end
                    end else begin
                        if (movx_p) cur_x <= next_x;
                        if (movy_p) cur_y <= next_y;
                    end
                end
                S_REQ: begin
                    if (shot_ready) shot_valid <= 1'b0;
                end
                S_WAIT: begin
                    if (res_valid) begin
                        // The LED stays lit through DONE, even on a malformed miss-with-over.
                        hit_led <= res_hit | res_over;
                        if (res_hit) begin
                            if (player) begin
                                if (score1 != 3'd7) score1 <= score1 + 3'd1;
                            end else begin
                                if (score0 != 3'd7) score0 <= score0 + 3'd1;
                            end
                        end
                        // Loaded with HOLD_CYCLES-1 so AIM is entered exactly HOLD_CYCLES edges later.
                        hold_cnt <= HW'(HOLD_CYCLES - 1);
                    end
                end
                S_SHOW: begin
                    if (hold_cnt == '0) begin
                        player  <= ~player;
                        cur_x   <= '0;
                        cur_y   <= '0;
                        hit_led <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                S_DONE: begin
                    if (start_p) begin
                        map0    <= '0;
                        map1    <= '0;
                        score0  <= 3'd0;
                        score1  <= 3'd0;
                        cur_x   <= '0;
                        cur_y   <= '0;
                        player  <= 1'b0;
                        hit_led <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shot_entry_ctrl.sv
`timescale 1ns/1ps
module tb_shot_entry_ctrl;

    localparam int GRID = 4;
    localparam int CW   = 2;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_p, movx_p, movy_p, fire_p;
    logic          shot_valid, shot_ready;
    logic [CW-1:0] shot_x, shot_y;
    logic          shot_player;
    logic          res_valid, res_hit, res_over;
    logic [CW-1:0] cur_x, cur_y;
    logic          player, hit_led, dup_err;
    logic [2:0]    score0, score1, state_o;

    always #5 clk = ~clk;

    shot_entry_ctrl #(.GRID(GRID), .CW(CW), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst),
        .start_p(start_p), .movx_p(movx_p), .movy_p(movy_p), .fire_p(fire_p),
        .shot_valid(shot_valid), .shot_ready(shot_ready),
        .shot_x(shot_x), .shot_y(shot_y), .shot_player(shot_player),
        .res_valid(res_valid), .res_hit(res_hit), .res_over(res_over),
        .cur_x(cur_x), .cur_y(cur_y), .player(player),
        .hit_led(hit_led), .dup_err(dup_err),
        .score0(score0), .score1(score1), .state_o(state_o)
    );

    // Reference model: game phase by its display number, scores as integers,
    // shot history as a plain per-player cell array, SHOW end as an absolute edge number.
    localparam int PH_IDLE = 0, PH_AIM = 1, PH_REQ = 2, PH_WAIT = 3, PH_SHOW = 4, PH_DONE = 5;
    int m_state, m_cx, m_cy, m_player, m_s0, m_s1, m_hit, m_dup, m_sx, m_sy, m_sp;
    bit m_map[2][GRID*GRID];
    int cyc, show_until;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = PH_IDLE; m_cx = 0; m_cy = 0; m_player = 0; m_s0 = 0; m_s1 = 0;
        m_hit = 0; m_dup = 0; m_sx = 0; m_sy = 0; m_sp = 0; show_until = 0; cyc = 0;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < GRID*GRID; c++) m_map[p][c] = 1'b0;
    endtask

    // Applies the rules to the inputs that the next rising edge will sample.
    task automatic model_step();
        int idx;
        m_dup = 0;
        case (m_state)
            PH_IDLE: if (start_p) m_state = PH_AIM;
            PH_AIM: begin
                if (fire_p) begin
                    idx = m_cy * GRID + m_cx;
                    if (m_map[m_player][idx]) m_dup = 1;
                    else begin
                        m_map[m_player][idx] = 1'b1;
                        m_sx = m_cx; m_sy = m_cy; m_sp = m_player;
                        m_state = PH_REQ;
                    end
                end else begin
                    if (movx_p) m_cx = (m_cx + 1) % GRID;
                    if (movy_p) m_cy = (m_cy + 1) % GRID;
                end
            end
            PH_REQ: if (shot_ready) m_state = PH_WAIT;
            PH_WAIT: begin
                if (res_valid) begin
                    m_hit = (res_hit || res_over) ? 1 : 0;
                    if (res_hit) begin
                        if (m_player == 0) m_s0 = (m_s0 < 7) ? m_s0 + 1 : 7;
                        else               m_s1 = (m_s1 < 7) ? m_s1 + 1 : 7;
                    end
                    if (res_over) m_state = PH_DONE;
                    else begin
                        m_state = PH_SHOW;
                        show_until = cyc + HOLD;
                    end
                end
            end
            PH_SHOW: begin
                if (cyc == show_until) begin
                    m_player = 1 - m_player;
                    m_cx = 0; m_cy = 0; m_hit = 0;
                    m_state = PH_AIM;
                end
            end
            PH_DONE: begin
                if (start_p) begin
                    for (int p = 0; p < 2; p++)
                        for (int c = 0; c < GRID*GRID; c++) m_map[p][c] = 1'b0;
                    m_s0 = 0; m_s1 = 0; m_cx = 0; m_cy = 0; m_player = 0; m_hit = 0;
                    m_state = PH_AIM;
                end
            end
            default: ;
        endcase
        cyc++;
    endtask

    task automatic check_all();
        chk("state", state_o, m_state);
        chk("cur_x", cur_x, m_cx);
        chk("cur_y", cur_y, m_cy);
        chk("player", player, m_player);
        chk("hit_led", hit_led, m_hit);
        chk("dup_err", dup_err, m_dup);
        chk("score0", score0, m_s0);
        chk("score1", score1, m_s1);
        chk("shot_valid", shot_valid, (m_state == PH_REQ) ? 1 : 0);
        if (m_state == PH_REQ) begin
            chk("shot_x", shot_x, m_sx);
            chk("shot_y", shot_y, m_sy);
            chk("shot_player", shot_player, m_sp);
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, compare at the next falling edge.
    task automatic step(input bit s, input bit mx, input bit my, input bit f,
                        input bit rdy, input bit rv, input bit rh, input bit ro);
        start_p = s; movx_p = mx; movy_p = my; fire_p = f;
        shot_ready = rdy; res_valid = rv; res_hit = rh; res_over = ro;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // From AIM with the cursor at (0,0): aim, fire, hand shake, result, and hold if not over.
    task automatic do_shot(input int nx, input int ny, input bit hit, input bit over);
        repeat (nx) step(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (ny) step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, hit, over);
        if (!over) idle(HOLD);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start_p = 0; movx_p = 0; movy_p = 0; fire_p = 0;
        shot_ready = 0; res_valid = 0; res_hit = 0; res_over = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("lit_reset_state", state_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check_all();

        // Cursor movement and wrap.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("lit_cur_x_3", cur_x, 3);
        chk("lit_cur_y_2", cur_y, 2);
        chk("model_cur_x_3", m_cx, 3);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("lit_cur_x_wrap", cur_x, 0);

        // Fire at (1,2) with ready held low.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            chk("lit_req_valid", shot_valid, 1);
            chk("lit_req_x", shot_x, 1);
            chk("lit_req_y", shot_y, 2);
            chk("lit_req_player", shot_player, 0);
        end
        step(0, 0, 0, 0, 1, 0, 0, 0);
        chk("lit_wait", state_o, 3);

        // Hit result and hold timing.
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("lit_score0_1", score0, 1);
        chk("lit_hit_led", hit_led, 1);
        chk("lit_show", state_o, 4);
        chk("model_score0_1", m_s0, 1);
        idle(HOLD - 1);
        chk("lit_still_show", state_o, 4);
        idle(1);
        chk("lit_aim_after_hold", state_o, 1);
        chk("lit_player_1", player, 1);
        chk("lit_cursor_home", {cur_y, cur_x}, 0);

        // Turns leading to a duplicate shot by player 0 at (0,0).
        do_shot(3, 3, 0, 0);
        do_shot(0, 0, 0, 0);
        do_shot(1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0);
        chk("lit_dup_err", dup_err, 1);
        chk("lit_dup_no_valid", shot_valid, 0);
        chk("lit_dup_aim", state_o, 1);
        idle(1);
        chk("lit_dup_one_cycle", dup_err, 0);

        // Fire beats a same-cycle move.
        repeat (2) step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        chk("lit_fire_move_shot_x", shot_x, 2);
        chk("lit_fire_move_cur_x", cur_x, 2);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(HOLD);

        // Player 1 wins, then restart.
        do_shot(0, 1, 1, 1);
        chk("lit_done", state_o, 5);
        chk("lit_done_player", player, 1);
        chk("lit_done_score1", score1, 1);
        step(0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("lit_done_frozen", state_o, 5);
        chk("lit_done_cur_y", cur_y, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_restart_aim", state_o, 1);
        chk("lit_restart_s0", score0, 0);
        chk("lit_restart_s1", score1, 0);
        chk("lit_restart_player", player, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("lit_map_cleared", shot_valid, 1);

        // Asynchronous reset in the middle of a request.
        step(1, 0, 0, 0, 0, 1, 1, 1);
        rst = 1'b1;
        #1;
        chk("lit_async_rst_valid", shot_valid, 0);
        chk("lit_async_rst_state", state_o, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
